// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared states, constants and helpers for the SPI command arbiter
//
// Purpose:
//   Common definitions imported by the arbiter, its round-robin picker and its
//   bus interface. The default command/read widths are the same constants the
//   SPI master is built with, so both sides of the command port agree.
//
// Contents:
//   DEFAULT_CMD_WIDTH   default command width (bit CMD_WIDTH-1 selects read)
//   DEFAULT_READ_WIDTH  default read data width
//   arb_state_e         arbiter FSM states IDLE / ISSUE / WAIT_RD
//   rd_bit()            index of the read/write flag inside a command word
//
// Ports: none.

package spi_pkg;

  localparam int DEFAULT_CMD_WIDTH  = 12;
  localparam int DEFAULT_READ_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

  // The command MSB carries the direction: 1 = read, 0 = write.
  function automatic int rd_bit(input int cmd_width);
    return cmd_width - 1;
  endfunction

endpackage

// File: rtl/spi_cmd_arbiter_if.sv
// rtl/spi_cmd_arbiter_if.sv - bus bundle between requesters, arbiter and SPI master
//
// Purpose:
//   Groups every handshake/data signal of the SPI command arbiter. Clock and
//   reset stay plain ports on the modules.
//
// Signals:
//   req_cmd     NUM_REQ*CMD_WIDTH  packed commands, slice i belongs to requester i
//   req_vld     NUM_REQ            per-requester command valid
//   req_rdy     NUM_REQ            per-requester accept (one-hot or zero)
//   rsp_vld     NUM_REQ            one-cycle read-data strobe to the owner
//   rsp_data    READ_WIDTH         shared read data, qualified by rsp_vld
//   rsp_err     1                  read timeout flag, valid with rsp_vld
//   m_cmd       CMD_WIDTH          command to the SPI master
//   m_cmd_vld   1                  command valid to the SPI master
//   m_cmd_rdy   1                  SPI master ready
//   m_read_vld  1                  SPI master read data valid
//   m_read_data READ_WIDTH         SPI master read data
//   busy        1                  arbiter owns a transaction
//   gnt_id      $clog2(NUM_REQ)    current/last granted requester
//
// Modports:
//   master  arbiter view (drives the SPI command port and the requester replies)
//   slave   environment view (requesters plus SPI master)

interface spi_cmd_arbiter_if
  import spi_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int CMD_WIDTH  = DEFAULT_CMD_WIDTH,
  parameter int READ_WIDTH = DEFAULT_READ_WIDTH
) ();

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd;
  logic [NUM_REQ-1:0]           req_vld;
  logic [NUM_REQ-1:0]           req_rdy;
  logic [NUM_REQ-1:0]           rsp_vld;
  logic [READ_WIDTH-1:0]        rsp_data;
  logic                         rsp_err;
  logic [CMD_WIDTH-1:0]         m_cmd;
  logic                         m_cmd_vld;
  logic                         m_cmd_rdy;
  logic                         m_read_vld;
  logic [READ_WIDTH-1:0]        m_read_data;
  logic                         busy;
  logic [IDX_W-1:0]             gnt_id;

  modport master (
    input  req_cmd, req_vld, m_cmd_rdy, m_read_vld, m_read_data,
    output req_rdy, rsp_vld, rsp_data, rsp_err, m_cmd, m_cmd_vld, busy, gnt_id
  );

  modport slave (
    output req_cmd, req_vld, m_cmd_rdy, m_read_vld, m_read_data,
    input  req_rdy, rsp_vld, rsp_data, rsp_err, m_cmd, m_cmd_vld, busy, gnt_id
  );

endinterface

// File: rtl/spi_rr_picker.sv
// rtl/spi_rr_picker.sv - combinational round-robin pick of the next requester
//
// Purpose:
//   Returns the first asserted request at or after rr_ptr, wrapping at
//   NUM_REQ-1 -> 0 (also for NUM_REQ that is not a power of two).
//
// Ports:
//   req      in   NUM_REQ          request vector
//   rr_ptr   in   $clog2(NUM_REQ)  highest-priority index this cycle
//   gnt      out  NUM_REQ          one-hot of the winner, zero when no request
//   gnt_idx  out  $clog2(NUM_REQ)  index of the winner (0 when no request)
//   any      out  1                at least one request present

module spi_rr_picker
  import spi_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  // One extra bit so rr_ptr + offset can be wrapped by a single subtraction.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// rtl/spi_cmd_arbiter.sv - round-robin arbiter sharing one SPI master command port
//
// Purpose:
//   NUM_REQ requesters share one SPI master. A grant is held for the whole
//   transaction: a write until the master takes the command, a read until the
//   read data comes back. Read data is strobed only to the owning requester.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (shared with the SPI master)
//   bus    spi_cmd_arbiter_if.master: req_cmd/req_vld/req_rdy,
//          rsp_vld/rsp_data/rsp_err, m_cmd/m_cmd_vld/m_cmd_rdy,
//          m_read_vld/m_read_data, busy, gnt_id
//
// Configuration macro:
//   SPI_ARB_TIMEOUT_EN  adds a read watchdog; an unanswered read is completed
//                       with rsp_err=1 and rsp_data=0 TIMEOUT_CYCLES cycles
//                       after the master accepted it. Undefined: WAIT_RD waits
//                       forever and rsp_err is tied 0.

module spi_cmd_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int CMD_WIDTH      = DEFAULT_CMD_WIDTH,
  parameter int READ_WIDTH     = DEFAULT_READ_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                rst_n,
  spi_cmd_arbiter_if.master  bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int RD_BIT = rd_bit(CMD_WIDTH);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("spi_cmd_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("spi_cmd_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  arb_state_e            state_q, state_d;
  logic [CMD_WIDTH-1:0]  buff_q, buff_d;
  logic                  is_rd_q, is_rd_d;
  logic [IDX_W-1:0]      gnt_id_q, gnt_id_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    rsp_vld_q, rsp_vld_d;
  logic [READ_WIDTH-1:0] rsp_data_q, rsp_data_d;

`ifdef SPI_ARB_TIMEOUT_EN
  // The counter is loaded with 1 on the master handshake, so it holds the
  // number of cycles elapsed since the read was accepted; the response then
  // lands exactly TIMEOUT_CYCLES cycles after that handshake.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic                  rsp_err_q, rsp_err_d;
  logic [15:0]           cnt_q, cnt_d;
`endif

  // Unpack the requester command slices.
  logic [CMD_WIDTH-1:0] cmd_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cmd
    assign cmd_arr[i] = bus.req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
  end

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  spi_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req     (bus.req_vld),
    .rr_ptr  (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      buff_q     <= '0;
      is_rd_q    <= 1'b0;
      gnt_id_q   <= '0;
      rr_ptr_q   <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buff_q     <= buff_d;
      is_rd_q    <= is_rd_d;
      gnt_id_q   <= gnt_id_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    buff_d     = buff_q;
    is_rd_d    = is_rd_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
    rsp_err_d  = 1'b0;
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          buff_d   = cmd_arr[pick_idx];
          is_rd_d  = cmd_arr[pick_idx][RD_BIT];
          gnt_id_d = pick_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_cmd_rdy) begin
          // Priority moves past the requester just served, so a lone
          // requester still wins again on the very next IDLE cycle.
          rr_ptr_d = (gnt_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
          state_d  = is_rd_q ? WAIT_RD : IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_d    = 16'd1;
`endif
        end
      end
      WAIT_RD: begin
        // Real read data takes priority over a watchdog expiring the same cycle.
        if (bus.m_read_vld) begin
          rsp_vld_d[gnt_id_q] = 1'b1;
          rsp_data_d          = bus.m_read_data;
          state_d             = IDLE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rsp_vld_d[gnt_id_q] = 1'b1;
          rsp_err_d           = 1'b1;
          rsp_data_d          = '0;
          state_d             = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // req_rdy is gated with rst_n so nothing is accepted while reset is held.
  assign bus.req_rdy   = (rst_n && state_q == IDLE) ? pick_gnt : '0;
  assign bus.m_cmd     = buff_q;
  assign bus.m_cmd_vld = (state_q == ISSUE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.gnt_id    = gnt_id_q;
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// tb/tb_spi_cmd_arbiter.sv - self-checking bench for spi_cmd_arbiter

module tb_spi_cmd_arbiter;
  import spi_pkg::*;

  localparam int N  = 4;
  localparam int CW = 12;
  localparam int RW = 8;
  localparam int TO = 16;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int RD_DELAY = 10;
`else
  localparam int RD_DELAY = 20;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_cmd_arbiter_if #(.NUM_REQ(N), .CMD_WIDTH(CW), .READ_WIDTH(RW)) bus ();

  spi_cmd_arbiter #(
    .NUM_REQ(N), .CMD_WIDTH(CW), .READ_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Requester-side stimulus.
  logic [N-1:0]  req_vld_a;
  logic [CW-1:0] req_cmd_a [N];
  bit            auto_drop;

  // Transaction-level reference: who owns the port and what is owed to them.
  int            phase;     // 0 free, 1 command offered to master, 2 owed read data
  int            owner;
  int            prio;      // first requester considered at the next grant
  int            waited;    // cycles since the master took a read
  int            mdl_gnt;
  logic [CW-1:0] mdl_cmd;
  logic [RW-1:0] mdl_data;
  logic [N-1:0]  mdl_rsp;
  logic          mdl_err;
  logic [N-1:0]  glog [$];  // accepts observed on the DUT, in order

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) bus.req_cmd[i*CW +: CW] = req_cmd_a[i];
    bus.req_vld = req_vld_a;
  endtask

  task automatic model_reset();
    phase = 0; owner = 0; prio = 0; waited = 0; mdl_gnt = 0;
    mdl_cmd = '0; mdl_data = '0; mdl_rsp = '0; mdl_err = 1'b0;
  endtask

  // One clock: check combinational outputs before the edge, advance the
  // reference, check registered outputs just after the edge.
  task automatic step();
    int           pick;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] obs_acc;
    drive_reqs();
    #1;
    pick = -1;
    if (phase == 0) begin
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && req_vld_a[(prio + k) % N]) pick = (prio + k) % N;
      end
    end
    exp_rdy = '0;
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    chk("req_rdy",   32'(bus.req_rdy),   32'(exp_rdy));
    chk("m_cmd_vld", 32'(bus.m_cmd_vld), 32'(phase == 1));
    chk("m_cmd",     32'(bus.m_cmd),     32'(mdl_cmd));
    chk("busy",      32'(bus.busy),      32'(phase != 0));
    obs_acc = bus.req_rdy & req_vld_a;
    if (obs_acc != '0) glog.push_back(obs_acc);

    mdl_rsp = '0;
    mdl_err = 1'b0;
    case (phase)
      0: begin
        if (pick >= 0) begin
          owner = pick; mdl_gnt = pick; mdl_cmd = req_cmd_a[pick]; phase = 1;
        end
      end
      1: begin
        if (bus.m_cmd_rdy) begin
          prio   = (owner + 1) % N;
          phase  = mdl_cmd[CW-1] ? 2 : 0;
          waited = 1;
        end
      end
      2: begin
        if (bus.m_read_vld) begin
          mdl_rsp[owner] = 1'b1; mdl_data = bus.m_read_data; phase = 0;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (waited == TO - 1) begin
          mdl_rsp[owner] = 1'b1; mdl_err = 1'b1; mdl_data = '0; phase = 0;
        end else begin
          waited++;
        end
`endif
      end
      default: ;
    endcase

    @(posedge clk);
    #1;
    chk("rsp_vld",  32'(bus.rsp_vld),  32'(mdl_rsp));
    chk("rsp_err",  32'(bus.rsp_err),  32'(mdl_err));
    chk("rsp_data", 32'(bus.rsp_data), 32'(mdl_data));
    chk("gnt_id",   32'(bus.gnt_id),   32'(mdl_gnt));
    if (auto_drop) req_vld_a = req_vld_a & ~exp_rdy;
  endtask

  task automatic reset_check(input string pfx);
    drive_reqs();
    rst_n = 1'b0;
    #1;
    chk({pfx, "_m_cmd"},     32'(bus.m_cmd),     32'h0);
    chk({pfx, "_m_cmd_vld"}, 32'(bus.m_cmd_vld), 32'h0);
    chk({pfx, "_rsp_vld"},   32'(bus.rsp_vld),   32'h0);
    chk({pfx, "_rsp_data"},  32'(bus.rsp_data),  32'h0);
    chk({pfx, "_rsp_err"},   32'(bus.rsp_err),   32'h0);
    chk({pfx, "_busy"},      32'(bus.busy),      32'h0);
    chk({pfx, "_gnt_id"},    32'(bus.gnt_id),    32'h0);
    chk({pfx, "_req_rdy"},   32'(bus.req_rdy),   32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    req_vld_a = '0;
    for (int i = 0; i < N; i++) req_cmd_a[i] = '0;
    auto_drop        = 1'b1;
    bus.m_cmd_rdy    = 1'b0;
    bus.m_read_vld   = 1'b0;
    bus.m_read_data  = '0;
    model_reset();
    drive_reqs();
    @(posedge clk);
    #1;

    // Power-up reset, with all requesters asking.
    req_vld_a = 4'b1111;
    reset_check("rst_init");
    req_vld_a = '0;

    // Single write from requester 0.
    req_cmd_a[0] = 12'h0A5; req_vld_a = 4'b0001; bus.m_cmd_rdy = 1'b1;
    step();
    chk("wr_m_cmd",     32'(bus.m_cmd),     32'h0A5);
    chk("wr_m_cmd_vld", 32'(bus.m_cmd_vld), 32'h1);
    step();
    chk("wr_busy_low",  32'(bus.busy),      32'h0);
    step();

    // Single read from requester 2.
    req_cmd_a[2] = 12'h8C3; req_vld_a = 4'b0100;
    step();
    step();
    repeat (RD_DELAY - 1) step();
    bus.m_read_vld = 1'b1; bus.m_read_data = 8'h5A;
    step();
    chk("rd_rsp_vld",  32'(bus.rsp_vld),  32'h4);
    chk("rd_rsp_data", 32'(bus.rsp_data), 32'h5A);
    chk("rd_rsp_err",  32'(bus.rsp_err),  32'h0);
    bus.m_read_vld = 1'b0;
    step();

    // Reset while a read from requester 1 is outstanding.
    req_cmd_a[1] = 12'h9F0; req_vld_a = 4'b0010;
    step();
    step();
    step();
    chk("mid_busy", 32'(bus.busy), 32'h1);
    for (int i = 0; i < N; i++) req_cmd_a[i] = 12'h010 + 12'(i);
    req_vld_a = 4'b1111;
    reset_check("rst_mid");

    // Round robin with every requester holding a write request.
    auto_drop = 1'b0;
    glog.delete();
    repeat (10) step();
    chk("rr_count", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'(rr_exp[i]));
    req_vld_a = '0; auto_drop = 1'b1;
    step();

    // Backpressure from the SPI master.
    bus.m_cmd_rdy = 1'b0;
    req_cmd_a[0] = 12'h123; req_vld_a = 4'b0001;
    step();
    req_vld_a = 4'b1110;
    repeat (7) begin
      step();
      chk("bp_m_cmd",     32'(bus.m_cmd),     32'h123);
      chk("bp_m_cmd_vld", 32'(bus.m_cmd_vld), 32'h1);
      chk("bp_req_rdy",   32'(bus.req_rdy),   32'h0);
    end
    bus.m_cmd_rdy = 1'b1;
    repeat (8) step();
    req_vld_a = '0;
    repeat (2) step();

`ifdef SPI_ARB_TIMEOUT_EN
    // Unanswered read from requester 3, then a late read strobe.
    req_cmd_a[3] = 12'hC00; req_vld_a = 4'b1000;
    step();
    step();
    repeat (TO - 1) step();
    chk("to_rsp_vld",  32'(bus.rsp_vld),  32'h8);
    chk("to_rsp_err",  32'(bus.rsp_err),  32'h1);
    chk("to_rsp_data", 32'(bus.rsp_data), 32'h0);
    bus.m_read_vld = 1'b1; bus.m_read_data = 8'h77;
    step();
    chk("to_late_rsp_vld", 32'(bus.rsp_vld), 32'h0);
    bus.m_read_vld = 1'b0;
    step();
`endif

    // Randomized traffic against the reference.
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if (!req_vld_a[i] && $urandom_range(0, 2) == 0) begin
          req_vld_a[i] = 1'b1;
          req_cmd_a[i] = CW'($urandom);
        end
      end
      bus.m_cmd_rdy   = 1'($urandom_range(0, 1));
      bus.m_read_vld  = ($urandom_range(0, 3) == 0);
      bus.m_read_data = RW'($urandom);
      step();
    end
    req_vld_a = '0; bus.m_cmd_rdy = 1'b1; bus.m_read_vld = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
